// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V wide bus responder: lane count, word/block types, FSM and op encodings.
package rv32v_types_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [31:0]                  word_t;
    typedef word_t [NUM_LANES-1:0]        wide_word_t;
    typedef logic [NUM_LANES-1:0][3:0]    wide_be_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_WRITE_WIDE
    } op_t;

endpackage

// File: rtl/rv32v_wide_bus_responder_if.sv
// Initiator/responder bus carrying scalar and wide (block) loads and stores.
interface rv32v_wide_bus_responder_if;
    import rv32v_types_pkg::*;

    logic       ren;
    logic       wen;
    logic       wen_wide;
    logic [31:0] addr;
    word_t      wdata;
    logic [3:0] byte_en;
    wide_word_t wdata_wide;
    wide_be_t   byte_en_wide;
    word_t      rdata;
    wide_word_t rdata_wide;
    logic       busy;
    logic       err;

    modport master (
        output ren, wen, wen_wide, addr, wdata, byte_en, wdata_wide, byte_en_wide,
        input  rdata, rdata_wide, busy, err
    );

    modport slave (
        input  ren, wen, wen_wide, addr, wdata, byte_en, wdata_wide, byte_en_wide,
        output rdata, rdata_wide, busy, err
    );

endinterface

// File: rtl/rv32v_bytemask_merge.sv
// Combinational byte-lane merge: each set mask bit takes that byte from the new word.
module rv32v_bytemask_merge
    import rv32v_types_pkg::*;
(
    input  word_t      old_i,
    input  word_t      new_i,
    input  logic [3:0] mask_i,
    output word_t      merged_o
);

    // Select each byte from new or old according to its mask bit.
    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rv32v_wide_bus_responder.sv
// Memory-side responder: block-organised SRAM model with fixed access latency, serving
// scalar reads/writes and full-block writes, returning the word and the whole block.
module rv32v_wide_bus_responder
    import rv32v_types_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = NUM_LANES,
    parameter int unsigned NUM_BLOCKS  = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = '0
) (
    input  logic                          CLK,
    input  logic                          nRST,
    rv32v_wide_bus_responder_if.slave     bus
);

    localparam int unsigned WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int unsigned BLK_BITS  = $clog2(NUM_BLOCKS);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    op_t         op_q;
    logic        conflict_q;
    logic [31:0] addr_q;
    word_t       wdata_q;
    logic [3:0]  be_q;
    wide_word_t  wdata_wide_q;
    wide_be_t    be_wide_q;

    word_t       rdata_q;
    wide_word_t  rdata_wide_q;
    logic        err_q;

    wide_word_t  mem [NUM_BLOCKS];

    logic        req, req_conflict, commit, oor;
    op_t         req_op;

    op_t         eff_op;
    logic        eff_conflict;
    logic [31:0] eff_addr;
    word_t       eff_wdata;
    logic [3:0]  eff_be;
    wide_word_t  eff_wdata_wide;
    wide_be_t    eff_be_wide;

    logic [31:0]          word_full, blk_full;
    logic [WORD_BITS-1:0] word_idx;
    logic [BLK_BITS-1:0]  blk_idx;
    wide_word_t           cur_blk, merged_wide, new_blk;
    word_t                merged_word;

    // Request decode with wen_wide > wen > ren priority; more than one op flags a conflict.
    always_comb begin
        req          = bus.ren | bus.wen | bus.wen_wide;
        req_conflict = (2'(bus.ren) + 2'(bus.wen) + 2'(bus.wen_wide)) > 2'd1;
        if (bus.wen_wide)  req_op = OP_WRITE_WIDE;
        else if (bus.wen)  req_op = OP_WRITE;
        else               req_op = OP_READ;
    end

    // In IDLE the live bus is used so a zero-latency build can commit straight from the request;
    // otherwise the values captured at accept are used and later bus changes are ignored.
    always_comb begin
        if (state_q == IDLE) begin
            eff_op         = req_op;
            eff_conflict   = req_conflict;
            eff_addr       = bus.addr;
            eff_wdata      = bus.wdata;
            eff_be         = bus.byte_en;
            eff_wdata_wide = bus.wdata_wide;
            eff_be_wide    = bus.byte_en_wide;
        end else begin
            eff_op         = op_q;
            eff_conflict   = conflict_q;
            eff_addr       = addr_q;
            eff_wdata      = wdata_q;
            eff_be         = be_q;
            eff_wdata_wide = wdata_wide_q;
            eff_be_wide    = be_wide_q;
        end
    end

    // Address decode into block and word indices plus range check.
    always_comb begin
        word_full = (eff_addr - BASE_ADDR) >> 2;
        blk_full  = word_full >> WORD_BITS;
        oor       = (eff_addr < BASE_ADDR) || (blk_full >= 32'(NUM_BLOCKS));
        word_idx  = word_full[WORD_BITS-1:0];
        blk_idx   = blk_full[BLK_BITS-1:0];
        cur_blk   = mem[blk_idx];
    end

    rv32v_bytemask_merge u_merge_scalar (
        .old_i    (cur_blk[word_idx]),
        .new_i    (eff_wdata),
        .mask_i   (eff_be),
        .merged_o (merged_word)
    );

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rv32v_bytemask_merge u_merge_wide (
            .old_i    (cur_blk[k]),
            .new_i    (eff_wdata_wide[k]),
            .mask_i   (eff_be_wide[k]),
            .merged_o (merged_wide[k])
        );
    end

    // Post-operation block contents: reads see the block unchanged.
    always_comb begin
        new_blk = cur_blk;
        case (eff_op)
            OP_WRITE:      new_blk[word_idx] = merged_word;
            OP_WRITE_WIDE: new_blk = merged_wide;
            default:       new_blk = cur_blk;
        endcase
    end

    // Next-state logic: IDLE accepts, WAIT counts down the latency, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results are committed on the edge entering RESP so they are stable while busy is low.
    assign commit = (state_d == RESP);

    // Control state, request capture and registered response.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= OP_READ;
            conflict_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wdata_wide_q <= '0;
            be_wide_q    <= '0;
            rdata_q      <= '0;
            rdata_wide_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                op_q         <= req_op;
                conflict_q   <= req_conflict;
                addr_q       <= bus.addr;
                wdata_q      <= bus.wdata;
                be_q         <= bus.byte_en;
                wdata_wide_q <= bus.wdata_wide;
                be_wide_q    <= bus.byte_en_wide;
            end
            if (commit) begin
                err_q <= oor | eff_conflict;
                if (oor) begin
                    rdata_q      <= '0;
                    rdata_wide_q <= '0;
                end else begin
                    rdata_q      <= new_blk[word_idx];
                    rdata_wide_q <= new_blk;
                end
            end
        end
    end

    // Storage: one full-block write port, never cleared; gated off while reset is held.
    always_ff @(posedge CLK) begin
        if (commit && nRST && !oor && eff_op != OP_READ) begin
            mem[blk_idx] <= new_blk;
        end
    end

    assign bus.busy       = (state_q != RESP);
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.rdata_wide = rdata_wide_q;

endmodule
